if_fetch_redirect: RTL and testbench
====================================

Name: if_fetch_redirect

Overview:
- IF-stage PC owner; the consumer end of the EX-stage redirect interface (redirect_valid/redirect_pc).
- Generates instruction-memory requests and presents fetched instruction + PC+4 to the IF/ID register.
- Applies EX redirects, including flushing the two wrong-path instructions and squashing the in-flight fetch.
- Traps misaligned redirect targets to an exception vector.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0080, PC loaded when a redirect target is misaligned

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  downstream freeze; hold PC and IF/ID outputs
redirect_valid  in  1  EX-stage taken branch/jump
redirect_pc  in  32  EX-stage target
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (current PC)
imem_gnt  in  1  address accepted when imem_req && imem_gnt
imem_rdata  in  32  instruction, valid exactly 1 cycle after acceptance
ifid_valid  out  1  ifid_instr/ifid_pc4 hold a live instruction
ifid_instr  out  32  fetched instruction
ifid_pc4  out  32  fetch address + 4
flush_ifid  out  1  clear IF/ID this edge
flush_idex  out  1  clear ID/EX this edge
misalign_err  out  1  sticky: misaligned redirect seen
misalign_epc  out  32  offending redirect_pc

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - pc=RESET_PC; FSM=S_BOOT.
  - ifid_valid=0, ifid_instr=0, ifid_pc4=0.
  - misalign_err=0, misalign_epc=0.
  - inflight=0, squash=0, buffer empty.
- FSM:
  - S_BOOT: imem_req=0 for exactly one cycle after rst falls -> S_FETCH.
  - S_FETCH: imem_req = !stall && !redirect_valid; imem_addr=pc.
    - On accept: pc<=pc+4 (wraps mod 2^32), inflight<=1, inflight_pc4<=pc+4.
    - Response cycle (inflight=1) with stall=1: capture imem_rdata into a 1-entry buffer -> S_HOLD.
  - S_HOLD: imem_req=0; IF/ID outputs frozen. When stall=0, present the buffer (ifid_valid=1, unless squashed) -> S_FETCH.
- Response path: in the cycle after acceptance, if stall=0 and squash=0, ifid_* <= {1, imem_rdata, inflight_pc4} at the next edge. Otherwise ifid_valid<=0, except when stall=1, where outputs hold.
- Redirect (redirect_valid=1 in cycle N):
  - flush_ifid=flush_idex=1, combinational in cycle N.
  - imem_req=0 in cycle N.
  - A response arriving in cycle N is dropped; a request accepted in cycle N-1 sets squash so its data never reaches IF/ID.
  - Buffer cleared; S_HOLD -> S_FETCH.
  - pc<=redirect_pc at edge N.
  - Redirect wins over stall and over any pending accept/pc increment.
  - Redirect during S_BOOT: pc<=target, leave S_BOOT normally.
- Misalign: if redirect_pc[1:0]!=0, pc<=EXC_VECTOR, misalign_err<=1, misalign_epc<=redirect_pc. Flush behaviour is unchanged. misalign_err is cleared only by rst.
- Stall with no redirect:
  - pc held; no new request.
  - ifid_* and ifid_valid held.
  - flush outputs 0.
- imem_gnt=0 while requesting: pc and imem_addr held stable, imem_req stays high, no ifid_valid.
- Reset mid-operation: all state returns to reset values at the edge, any inflight response is discarded, and S_BOOT repeats.

Decomposition:
- Shared package mips_pkg:
  - fetch_state_t enum {S_BOOT, S_FETCH, S_HOLD}.
  - Constants INSTR_W=32, NOP_INSTR=32'h0.
- One natural sub-module: if_resp_buffer, the 1-entry skid buffer with valid, squash and clear inputs.
- PC/FSM logic stays in the top level.

Test Plan:
- Reset release, imem_gnt=1 constant -> no req for 1 cycle; imem_addr sequence 0x0,0x4,0x8; ifid_pc4 0x4,0x8,0xC, each one cycle after its address.
- redirect_valid=1, redirect_pc=0x0000_0100 while pc=0x10 -> flush_ifid=flush_idex=1 that cycle; the 0xC response is dropped; next imem_addr=0x100; first ifid_pc4=0x104.
- Redirect and stall in the same cycle, target 0x200 -> redirect wins: flush asserted, pc=0x200 the next cycle; no request while stall stays high.
- Stall raised in the response cycle for 3 cycles, imem_rdata=0x2402_0005 -> captured in the buffer; ifid_instr=0x2402_0005 appears once after stall drops; no duplicate; pc not advanced during stall.
- redirect_pc=0x0000_0102 -> pc=0x80; misalign_err=1 and stays 1; misalign_epc=0x102; a later aligned redirect does not clear it.
- imem_gnt=0 for 4 cycles at pc=0x40 -> imem_req=1 and imem_addr=0x40 held; ifid_valid=0; on grant, next address 0x44. pc=0xFFFF_FFFC accepted -> next pc=0x0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch slice.
// Contents:
//   fetch_state_t  - IF-stage sequencer states (boot, fetch, hold)
//   INSTR_W        - instruction width
//   NOP_INSTR      - value held in empty instruction registers
//   PC_STEP        - sequential fetch increment
//   is_misaligned  - true when an address is not word aligned
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP = 32'h0000_0004;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_resp_buffer.sv
// One-entry skid buffer for an instruction-memory response that arrives
// while the pipeline is frozen. The entry remembers whether it was marked
// as wrong-path when captured, so the consumer can drop it on release.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   capture         - load instr/pc4 into the entry
//   squash          - tag the captured entry as wrong-path
//   clear           - empty the entry (takes priority over capture)
//   capture_instr   - instruction word to store
//   capture_pc4     - fetch address + 4 to store
//   buf_valid       - entry occupied
//   buf_squashed    - occupied entry is wrong-path
//   buf_instr       - stored instruction
//   buf_pc4         - stored fetch address + 4
module if_resp_buffer
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               capture,
    input  logic               squash,
    input  logic               clear,
    input  logic [INSTR_W-1:0] capture_instr,
    input  logic [31:0]        capture_pc4,
    output logic               buf_valid,
    output logic               buf_squashed,
    output logic [INSTR_W-1:0] buf_instr,
    output logic [31:0]        buf_pc4
);

    logic               valid_r;
    logic               squashed_r;
    logic [INSTR_W-1:0] instr_r;
    logic [31:0]        pc4_r;

    // Entry storage: clear beats capture so a redirect always empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r    <= 1'b0;
            squashed_r <= 1'b0;
            instr_r    <= NOP_INSTR;
            pc4_r      <= 32'h0000_0000;
        end else if (clear) begin
            valid_r    <= 1'b0;
            squashed_r <= 1'b0;
        end else if (capture) begin
            valid_r    <= 1'b1;
            squashed_r <= squash;
            instr_r    <= capture_instr;
            pc4_r      <= capture_pc4;
        end else begin
            valid_r    <= valid_r;
            squashed_r <= squashed_r;
        end
    end

    assign buf_valid    = valid_r;
    assign buf_squashed = squashed_r;
    assign buf_instr    = instr_r;
    assign buf_pc4      = pc4_r;

endmodule

// File: rtl/if_fetch_redirect.sv
// IF-stage program-counter owner. Issues instruction-memory requests,
// forwards responses (instruction + PC+4) into the IF/ID register, and
// consumes EX-stage redirects: the two younger wrong-path instructions are
// flushed and the in-flight fetch is dropped. A misaligned redirect target
// is replaced by EXC_VECTOR and recorded in a sticky error register.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   stall                      - downstream freeze
//   redirect_valid/redirect_pc - EX-stage taken branch/jump and target
//   imem_req/imem_addr         - fetch request and address (current PC)
//   imem_gnt                   - request accepted this cycle
//   imem_rdata                 - instruction, one cycle after acceptance
//   ifid_valid/instr/pc4       - IF/ID register contents
//   flush_ifid/flush_idex      - combinational flush on redirect
//   misalign_err/misalign_epc  - sticky misalign flag and offending target
module if_fetch_redirect
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [31:0]        ifid_pc4,
    output logic               flush_ifid,
    output logic               flush_idex,
    output logic               misalign_err,
    output logic [31:0]        misalign_epc
);

    fetch_state_t       state_r, state_next_s;
    logic [31:0]        pc_r, pc_next_s;
    logic               inflight_r;
    logic [31:0]        inflight_pc4_r;
    logic               ifid_valid_r, ifid_valid_next_s;
    logic [INSTR_W-1:0] ifid_instr_r, ifid_instr_next_s;
    logic [31:0]        ifid_pc4_r, ifid_pc4_next_s;
    logic               misalign_err_r;
    logic [31:0]        misalign_epc_r;

    logic               req_s;
    logic               accept_s;
    logic               squash_s;
    logic               buf_capture_s;
    logic               buf_clear_s;
    logic               buf_valid_s;
    logic               buf_squashed_s;
    logic [INSTR_W-1:0] buf_instr_s;
    logic [31:0]        buf_pc4_s;

    // A redirect kills whatever response is arriving this cycle.
    assign squash_s = redirect_valid;

    // Capture a response that lands while frozen; release or redirect empties it.
    assign buf_capture_s = (state_r == S_FETCH) && inflight_r && stall;
    assign buf_clear_s   = redirect_valid || ((state_r == S_HOLD) && !stall);

    if_resp_buffer u_resp_buffer (
        .clk           (clk),
        .rst           (rst),
        .capture       (buf_capture_s),
        .squash        (squash_s),
        .clear         (buf_clear_s),
        .capture_instr (imem_rdata),
        .capture_pc4   (inflight_pc4_r),
        .buf_valid     (buf_valid_s),
        .buf_squashed  (buf_squashed_s),
        .buf_instr     (buf_instr_s),
        .buf_pc4       (buf_pc4_s)
    );

    // Sequencer next state, request generation and PC selection.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        req_s        = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            S_BOOT: begin
                state_next_s = S_FETCH;
            end
            S_FETCH: begin
                req_s = !stall && !redirect_valid;
                if (inflight_r && stall) begin
                    state_next_s = S_HOLD;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_HOLD;
                end
            end
            default: begin
                state_next_s = S_BOOT;
            end
        endcase
        accept_s = req_s && imem_gnt;
        // Redirect overrides stall, hold and any sequential increment.
        if (redirect_valid) begin
            state_next_s = S_FETCH;
            if (is_misaligned(redirect_pc)) begin
                pc_next_s = EXC_VECTOR;
            end else begin
                pc_next_s = redirect_pc;
            end
        end else if (accept_s) begin
            pc_next_s = pc_r + PC_STEP;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // IF/ID next contents: redirect clears, stall holds, otherwise load.
    always_comb begin
        ifid_valid_next_s = ifid_valid_r;
        ifid_instr_next_s = ifid_instr_r;
        ifid_pc4_next_s   = ifid_pc4_r;
        if (redirect_valid) begin
            ifid_valid_next_s = 1'b0;
        end else if (stall) begin
            ifid_valid_next_s = ifid_valid_r;
        end else if (state_r == S_HOLD) begin
            ifid_valid_next_s = buf_valid_s && !buf_squashed_s;
            ifid_instr_next_s = buf_instr_s;
            ifid_pc4_next_s   = buf_pc4_s;
        end else if ((state_r == S_FETCH) && inflight_r && !squash_s) begin
            ifid_valid_next_s = 1'b1;
            ifid_instr_next_s = imem_rdata;
            ifid_pc4_next_s   = inflight_pc4_r;
        end else begin
            ifid_valid_next_s = 1'b0;
        end
    end

    // State, PC, in-flight tracking and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= S_BOOT;
            pc_r           <= RESET_PC;
            inflight_r     <= 1'b0;
            inflight_pc4_r <= 32'h0000_0000;
            ifid_valid_r   <= 1'b0;
            ifid_instr_r   <= NOP_INSTR;
            ifid_pc4_r     <= 32'h0000_0000;
        end else begin
            state_r      <= state_next_s;
            pc_r         <= pc_next_s;
            inflight_r   <= accept_s;
            ifid_valid_r <= ifid_valid_next_s;
            ifid_instr_r <= ifid_instr_next_s;
            ifid_pc4_r   <= ifid_pc4_next_s;
            if (accept_s) begin
                inflight_pc4_r <= pc_r + PC_STEP;
            end else begin
                inflight_pc4_r <= inflight_pc4_r;
            end
        end
    end

    // Sticky misalign record; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err_r <= 1'b0;
            misalign_epc_r <= 32'h0000_0000;
        end else if (redirect_valid && is_misaligned(redirect_pc)) begin
            misalign_err_r <= 1'b1;
            misalign_epc_r <= redirect_pc;
        end else begin
            misalign_err_r <= misalign_err_r;
            misalign_epc_r <= misalign_epc_r;
        end
    end

    assign imem_req     = req_s;
    assign imem_addr    = pc_r;
    assign ifid_valid   = ifid_valid_r;
    assign ifid_instr   = ifid_instr_r;
    assign ifid_pc4     = ifid_pc4_r;
    assign flush_ifid   = redirect_valid;
    assign flush_idex   = redirect_valid;
    assign misalign_err = misalign_err_r;
    assign misalign_epc = misalign_epc_r;

endmodule

// File: tb/tb_if_fetch_redirect.sv
// Directed bench for if_fetch_redirect. Inputs change on the falling edge;
// combinational outputs are sampled 1 time unit before the rising edge and
// registered outputs 1 unit after it. A small memory responder returns
// rdata_for(addr) (or an override word) in the cycle after acceptance.
// Expected IF/ID deliveries are queued by the directed steps and popped
// whenever the IF/ID register is freshly loaded with a valid instruction.
module tb_if_fetch_redirect;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        flush_ifid;
    logic        flush_idex;
    logic        misalign_err;
    logic [31:0] misalign_epc;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_pc4_q[$];

    logic        override_en;
    logic [31:0] override_val;

    // Pre-edge snapshot of the cycle most recently ticked.
    logic        req_e;
    logic [31:0] addr_e;
    logic        fl_ifid_e;
    logic        fl_idex_e;
    logic        stall_e;
    logic        rst_e;

    always #5 clk = ~clk;

    if_fetch_redirect dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rdata     (imem_rdata),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc4       (ifid_pc4),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .misalign_err   (misalign_err),
        .misalign_epc   (misalign_epc)
    );

    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc4);
        exp_instr_q.push_back(instr);
        exp_pc4_q.push_back(pc4);
    endtask

    // One clock cycle: snapshot, edge, memory response, delivery scoreboard.
    task automatic tick();
        logic        acc;
        logic [31:0] acc_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        #4;
        req_e     = imem_req;
        addr_e    = imem_addr;
        fl_ifid_e = flush_ifid;
        fl_idex_e = flush_idex;
        stall_e   = stall;
        rst_e     = rst;
        acc       = imem_req && imem_gnt;
        acc_addr  = imem_addr;
        @(posedge clk);
        #1;
        if (acc) begin
            imem_rdata = override_en ? override_val : rdata_for(acc_addr);
        end else begin
            imem_rdata = 32'hDEAD_BEEF;
        end
        if (!rst_e && !stall_e && ifid_valid) begin
            checks++;
            assert (exp_instr_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_ifid observed pc4=%h instr=%h expected no delivery", ifid_pc4, ifid_instr);
            end
            if (exp_instr_q.size() != 0) begin
                e_instr = exp_instr_q.pop_front();
                e_pc4   = exp_pc4_q.pop_front();
                check32("ifid_instr", ifid_instr, e_instr);
                check32("ifid_pc4", ifid_pc4, e_pc4);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        imem_gnt       = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        override_en    = 1'b0;
        override_val   = 32'h0000_0000;
        @(negedge clk);

        // Reset values
        tick();
        tick();
        check1("rst_ifid_valid", ifid_valid, 1'b0);
        check32("rst_ifid_instr", ifid_instr, 32'h0000_0000);
        check32("rst_ifid_pc4", ifid_pc4, 32'h0000_0000);
        check1("rst_misalign_err", misalign_err, 1'b0);
        check32("rst_misalign_epc", misalign_epc, 32'h0000_0000);
        check1("rst_req", req_e, 1'b0);
        check32("rst_addr", imem_addr, 32'h0000_0000);

        // Boot cycle, then sequential fetch 0x0, 0x4, 0x8, 0xC
        rst = 1'b0;
        tick();
        check1("boot_no_req", req_e, 1'b0);
        push_exp(rdata_for(32'h0000_0000), 32'h0000_0004);
        push_exp(rdata_for(32'h0000_0004), 32'h0000_0008);
        push_exp(rdata_for(32'h0000_0008), 32'h0000_000C);
        tick();
        check1("fetch0_req", req_e, 1'b1);
        check32("fetch0_addr", addr_e, 32'h0000_0000);
        tick();
        check32("fetch1_addr", addr_e, 32'h0000_0004);
        tick();
        check32("fetch2_addr", addr_e, 32'h0000_0008);
        tick();
        check32("fetch3_addr", addr_e, 32'h0000_000C);

        // Redirect to 0x100 at pc=0x10; the 0xC response is dropped
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        check32("redir_at_pc", addr_e, 32'h0000_0010);
        check1("redir_flush_ifid", fl_ifid_e, 1'b1);
        check1("redir_flush_idex", fl_idex_e, 1'b1);
        check1("redir_no_req", req_e, 1'b0);
        check1("redir_ifid_cleared", ifid_valid, 1'b0);
        push_exp(rdata_for(32'h0000_0100), 32'h0000_0104);
        tick();
        check32("redir_target_addr", addr_e, 32'h0000_0100);
        check1("redir_target_req", req_e, 1'b1);
        tick();
        check32("redir_next_addr", addr_e, 32'h0000_0104);

        // Redirect and stall together: redirect wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        stall          = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check1("rs_flush_ifid", fl_ifid_e, 1'b1);
        check1("rs_flush_idex", fl_idex_e, 1'b1);
        check1("rs_no_req", req_e, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check32("rs_stalled_addr", addr_e, 32'h0000_0200);
            check1("rs_stalled_no_req", req_e, 1'b0);
            check1("rs_stalled_no_flush", fl_ifid_e, 1'b0);
        end
        stall        = 1'b0;
        override_en  = 1'b1;
        override_val = 32'h2402_0005;
        push_exp(32'h2402_0005, 32'h0000_0204);
        tick();
        check32("rs_resume_addr", addr_e, 32'h0000_0200);
        check1("rs_resume_req", req_e, 1'b1);
        override_en = 1'b0;

        // Stall in the response cycle for 3 cycles: buffered, shown once
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check32("hold_pc_frozen", addr_e, 32'h0000_0204);
            check1("hold_no_req", req_e, 1'b0);
        end
        stall = 1'b0;
        tick();
        check1("hold_release_no_req", req_e, 1'b0);
        check1("hold_release_valid", ifid_valid, 1'b1);
        push_exp(rdata_for(32'h0000_0204), 32'h0000_0208);
        tick();
        check32("hold_after_addr", addr_e, 32'h0000_0204);
        check1("hold_no_duplicate", ifid_valid, 1'b0);
        // 0x204 is in flight and is dropped by the redirect below
        void'(exp_instr_q.pop_back());
        void'(exp_pc4_q.pop_back());

        // Misaligned redirect traps to the exception vector
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        check1("mis_flush", fl_ifid_e, 1'b1);
        check1("mis_err", misalign_err, 1'b1);
        check32("mis_epc", misalign_epc, 32'h0000_0102);
        redirect_valid = 1'b0;
        tick();
        check32("mis_vector_addr", addr_e, 32'h0000_0080);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        check1("mis_err_sticky", misalign_err, 1'b1);
        check32("mis_epc_sticky", misalign_epc, 32'h0000_0102);

        // Grant withheld for 4 cycles at pc=0x40
        imem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check1("nogrant_req", req_e, 1'b1);
            check32("nogrant_addr", addr_e, 32'h0000_0040);
            check1("nogrant_no_valid", ifid_valid, 1'b0);
        end
        imem_gnt = 1'b1;
        push_exp(rdata_for(32'h0000_0040), 32'h0000_0044);
        tick();
        check32("grant_addr", addr_e, 32'h0000_0040);
        tick();
        check32("grant_next_addr", addr_e, 32'h0000_0044);

        // PC wrap from 0xFFFF_FFFC
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        push_exp(rdata_for(32'hFFFF_FFFC), 32'h0000_0000);
        tick();
        check32("wrap_addr", addr_e, 32'hFFFF_FFFC);
        tick();
        check32("wrap_next_addr", addr_e, 32'h0000_0000);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        tick();
        check32("pre_reset_addr", addr_e, 32'h0000_0300);

        // Reset mid-operation with a response in flight
        rst = 1'b1;
        tick();
        check1("mid_rst_valid", ifid_valid, 1'b0);
        check32("mid_rst_pc4", ifid_pc4, 32'h0000_0000);
        check1("mid_rst_err", misalign_err, 1'b0);
        check32("mid_rst_epc", misalign_epc, 32'h0000_0000);
        check32("mid_rst_addr", imem_addr, 32'h0000_0000);

        // Redirect during the boot cycle
        rst            = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0500;
        tick();
        redirect_valid = 1'b0;
        check1("boot_redir_no_req", req_e, 1'b0);
        check1("boot_redir_flush", fl_idex_e, 1'b1);
        check1("boot_redir_no_valid", ifid_valid, 1'b0);
        push_exp(rdata_for(32'h0000_0500), 32'h0000_0504);
        tick();
        check32("boot_redir_addr", addr_e, 32'h0000_0500);
        check1("boot_redir_req", req_e, 1'b1);
        tick();
        stall = 1'b1;
        tick();
        tick();

        check32("scoreboard_empty", exp_instr_q.size(), 32'h0000_0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
